// File: rtl/axi_rd_slave_emu_if.sv
// AXI4 read-address/read-data bundle for the multi-channel read-slave emulator.
// One packed lane per channel; the master modport is the requester side.
interface axi_rd_slave_emu_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDRWIDTH = 36,
  parameter int unsigned DATAWIDTH = 1024
);
  logic [NUM_CH-1:0][ADDRWIDTH-1:0] s_axi_araddr;
  logic [NUM_CH-1:0][1:0]           s_axi_arburst;
  logic [NUM_CH-1:0][7:0]           s_axi_arlen;
  logic [NUM_CH-1:0][2:0]           s_axi_arsize;
  logic [NUM_CH-1:0]                s_axi_arvalid;
  logic [NUM_CH-1:0]                s_axi_arready;
  logic [NUM_CH-1:0][DATAWIDTH-1:0] s_axi_rdata;
  logic [NUM_CH-1:0][1:0]           s_axi_rresp;
  logic [NUM_CH-1:0]                s_axi_rlast;
  logic [NUM_CH-1:0]                s_axi_rvalid;
  logic [NUM_CH-1:0]                s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arsize, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arsize, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_rd_slave_emu.sv
// Multi-channel AXI4 read-slave responder: independent per-channel FSMs with
// programmable first-beat latency, synthetic data patterns and SLVERR injection.
module axi_rd_slave_emu #(
  parameter int unsigned           NUM_CH    = 4,
  parameter int unsigned           ADDRWIDTH = 36,
  parameter int unsigned           DATAWIDTH = 1024,
  parameter int unsigned           LATENCY   = 2,
  parameter int unsigned           DATA_MODE = 0,
  parameter logic [31:0]           DATA_BASE = 32'd0,
  parameter logic [ADDRWIDTH-1:0]  MEM_LIMIT = {ADDRWIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_rd_slave_emu_if.slave       axi,
  output logic [NUM_CH-1:0][15:0] burst_cnt_o,
  output logic [NUM_CH-1:0]       busy_o
);

  localparam int unsigned BEAT_W = 9;
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (LATENCY == 0) ? WAIT_W'(0) : WAIT_W'(LATENCY - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

  // Out-of-range start addresses and WRAP/reserved burst types are answered with SLVERR.
  function automatic logic burst_err(input logic [ADDRWIDTH-1:0] addr, input logic [1:0] burst);
    burst_err = (addr > MEM_LIMIT) || (burst == BURST_RSVD) || (burst == BURST_WRAP);
  endfunction

  function automatic logic [DATAWIDTH-1:0] beat_data(
    input logic [ADDRWIDTH-1:0] addr,
    input logic [2:0]           size,
    input logic [1:0]           burst,
    input logic                 err,
    input logic [BEAT_W-1:0]    beat
  );
    logic [ADDRWIDTH-1:0] beat_addr;
    logic [31:0]          beat_val;
    beat_data = '0;
    beat_addr = addr;
    beat_val  = 32'(beat) + DATA_BASE;
    if (burst == BURST_INCR) beat_addr = addr + (ADDRWIDTH'(beat) << size);
    if (err)                 beat_data = '0;
    else if (DATA_MODE == 0) beat_data = DATAWIDTH'(beat_val);
    else                     beat_data = DATAWIDTH'(beat_addr);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                 state;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [7:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic                   err_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [WAIT_W-1:0]      wait_q;
    logic                   arready_q;
    logic                   rvalid_q;
    logic                   rlast_q;
    logic [1:0]             rresp_q;
    logic [DATAWIDTH-1:0]   rdata_q;
    logic [15:0]            cnt_q;
    logic                   busy_q;

    logic                   ar_hs_c;
    logic                   r_hs_c;
    logic                   err_c;
    logic [BEAT_W-1:0]      beat_nxt_c;

    assign ar_hs_c    = axi.s_axi_arvalid[c] && arready_q;
    assign r_hs_c     = rvalid_q && axi.s_axi_rready[c];
    assign err_c      = burst_err(axi.s_axi_araddr[c], axi.s_axi_arburst[c]);
    assign beat_nxt_c = beat_q + BEAT_W'(1);

    // Per-channel request/response sequencer; all bus outputs are registered here.
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= ST_IDLE;
        addr_q    <= '0;
        len_q     <= '0;
        size_q    <= '0;
        burst_q   <= '0;
        err_q     <= 1'b0;
        beat_q    <= '0;
        wait_q    <= '0;
        arready_q <= 1'b1;
        rvalid_q  <= 1'b0;
        rlast_q   <= 1'b0;
        rresp_q   <= RESP_OKAY;
        rdata_q   <= '0;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ar_hs_c) begin
              addr_q    <= axi.s_axi_araddr[c];
              len_q     <= axi.s_axi_arlen[c];
              size_q    <= axi.s_axi_arsize[c];
              burst_q   <= axi.s_axi_arburst[c];
              err_q     <= err_c;
              beat_q    <= '0;
              arready_q <= 1'b0;
              busy_q    <= 1'b1;
              if (LATENCY == 0) begin
                state    <= ST_BURST;
                rvalid_q <= 1'b1;
                rlast_q  <= (axi.s_axi_arlen[c] == 8'd0);
                rresp_q  <= err_c ? RESP_SLVERR : RESP_OKAY;
                rdata_q  <= beat_data(axi.s_axi_araddr[c], axi.s_axi_arsize[c],
                                      axi.s_axi_arburst[c], err_c, BEAT_W'(0));
              end else begin
                state  <= ST_WAIT;
                wait_q <= WAIT_INIT;
              end
            end
          end

          ST_WAIT: begin
            if (wait_q == '0) begin
              state    <= ST_BURST;
              rvalid_q <= 1'b1;
              rlast_q  <= (len_q == 8'd0);
              rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
              rdata_q  <= beat_data(addr_q, size_q, burst_q, err_q, BEAT_W'(0));
            end else begin
              wait_q <= wait_q - WAIT_W'(1);
            end
          end

          ST_BURST: begin
            // Without a handshake every R field simply holds its value.
            if (r_hs_c) begin
              if (rlast_q) begin
                state     <= ST_IDLE;
                rvalid_q  <= 1'b0;
                rlast_q   <= 1'b0;
                rresp_q   <= RESP_OKAY;
                rdata_q   <= '0;
                arready_q <= 1'b1;
                busy_q    <= 1'b0;
                cnt_q     <= cnt_q + 16'd1;
              end else begin
                beat_q  <= beat_nxt_c;
                rlast_q <= (beat_nxt_c == {1'b0, len_q});
                rdata_q <= beat_data(addr_q, size_q, burst_q, err_q, beat_nxt_c);
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end

    assign axi.s_axi_arready[c] = arready_q;
    assign axi.s_axi_rvalid[c]  = rvalid_q;
    assign axi.s_axi_rlast[c]   = rlast_q;
    assign axi.s_axi_rresp[c]   = rresp_q;
    assign axi.s_axi_rdata[c]   = rdata_q;
    assign burst_cnt_o[c]       = cnt_q;
    assign busy_o[c]            = busy_q;
  end

endmodule

// File: tb/tb_axi_rd_slave_emu.sv
// Scoreboard bench for axi_rd_slave_emu: dut0 = mode 0 / LATENCY 2 / MEM_LIMIT 0xFFFF,
// dut1 = mode 1 (beat address) / LATENCY 0.
module tb_axi_rd_slave_emu;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 36;
  localparam int unsigned DW  = 128;
  localparam int unsigned NQ  = 2 * NCH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]                   rst_d;
  logic [1:0][NCH-1:0][AW-1:0]  araddr_d;
  logic [1:0][NCH-1:0][7:0]     arlen_d;
  logic [1:0][NCH-1:0][2:0]     arsize_d;
  logic [1:0][NCH-1:0][1:0]     arburst_d;
  logic [1:0][NCH-1:0]          arvalid_d;
  logic [1:0][NCH-1:0]          rready_d;

  logic [1:0][NCH-1:0]          arready_m, rvalid_m, rlast_m, busy_m;
  logic [1:0][NCH-1:0][DW-1:0]  rdata_m;
  logic [1:0][NCH-1:0][1:0]     rresp_m;
  logic [1:0][NCH-1:0][15:0]    cnt_m;

  axi_rd_slave_emu_if #(.NUM_CH(NCH), .ADDRWIDTH(AW), .DATAWIDTH(DW)) bus0 ();
  axi_rd_slave_emu_if #(.NUM_CH(NCH), .ADDRWIDTH(AW), .DATAWIDTH(DW)) bus1 ();

  axi_rd_slave_emu #(
    .NUM_CH(NCH), .ADDRWIDTH(AW), .DATAWIDTH(DW), .LATENCY(2), .DATA_MODE(0),
    .DATA_BASE(32'd0), .MEM_LIMIT(36'hFFFF)
  ) dut0 (
    .clk(clk), .rst(rst_d[0]), .axi(bus0.slave), .burst_cnt_o(cnt_m[0]), .busy_o(busy_m[0])
  );

  axi_rd_slave_emu #(
    .NUM_CH(NCH), .ADDRWIDTH(AW), .DATAWIDTH(DW), .LATENCY(0), .DATA_MODE(1),
    .DATA_BASE(32'd0), .MEM_LIMIT({AW{1'b1}})
  ) dut1 (
    .clk(clk), .rst(rst_d[1]), .axi(bus1.slave), .burst_cnt_o(cnt_m[1]), .busy_o(busy_m[1])
  );

  assign bus0.s_axi_araddr  = araddr_d[0];
  assign bus0.s_axi_arlen   = arlen_d[0];
  assign bus0.s_axi_arsize  = arsize_d[0];
  assign bus0.s_axi_arburst = arburst_d[0];
  assign bus0.s_axi_arvalid = arvalid_d[0];
  assign bus0.s_axi_rready  = rready_d[0];
  assign bus1.s_axi_araddr  = araddr_d[1];
  assign bus1.s_axi_arlen   = arlen_d[1];
  assign bus1.s_axi_arsize  = arsize_d[1];
  assign bus1.s_axi_arburst = arburst_d[1];
  assign bus1.s_axi_arvalid = arvalid_d[1];
  assign bus1.s_axi_rready  = rready_d[1];

  assign arready_m[0] = bus0.s_axi_arready;
  assign rvalid_m[0]  = bus0.s_axi_rvalid;
  assign rlast_m[0]   = bus0.s_axi_rlast;
  assign rresp_m[0]   = bus0.s_axi_rresp;
  assign rdata_m[0]   = bus0.s_axi_rdata;
  assign arready_m[1] = bus1.s_axi_arready;
  assign rvalid_m[1]  = bus1.s_axi_rvalid;
  assign rlast_m[1]   = bus1.s_axi_rlast;
  assign rresp_m[1]   = bus1.s_axi_rresp;
  assign rdata_m[1]   = bus1.s_axi_rdata;

  // Scoreboard: one expected-beat FIFO per (dut, channel), index k = dut*NCH + ch.
  exp_t        sb [NQ][512];
  int unsigned wp [NQ];
  int unsigned rp [NQ];
  int unsigned hs [NQ];
  int unsigned exp_cnt [NQ];
  bit          held_v [NQ];
  exp_t        held_e [NQ];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [DW+2:0] act, input logic [DW+2:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] data, input logic [1:0] resp, input logic last);
    exp_t e;
    e.data = data;
    e.resp = resp;
    e.last = last;
    sb[k][wp[k] % 512] = e;
    wp[k]++;
  endtask

  // Mode-0 bursts: beat index as data, or zero data on an error burst.
  task automatic push_idx(input int k, input int len, input logic err);
    for (int b = 0; b <= len; b++)
      push(k, err ? DW'(0) : DW'(b), err ? 2'b10 : 2'b00, b == len);
  endtask

  // Monitor: pops and compares every handshaken beat, checks stability across stalls.
  int   mk;
  exp_t mcur;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        mk = d * NCH + c;
        mcur.data = rdata_m[d][c];
        mcur.resp = rresp_m[d][c];
        mcur.last = rlast_m[d][c];
        if (rst_d[d]) begin
          held_v[mk] = 1'b0;
        end else begin
          if (held_v[mk] && rvalid_m[d][c])
            chk($sformatf("stall_hold d%0d c%0d", d, c), mcur, held_e[mk]);
          held_v[mk] = rvalid_m[d][c] && !rready_d[d][c];
          held_e[mk] = mcur;
          if (rvalid_m[d][c] && rready_d[d][c]) begin
            hs[mk]++;
            if (rp[mk] == wp[mk]) begin
              nchk++;
              nerr++;
              $display("FAIL unexpected_beat d%0d c%0d: got %0h expected none", d, c, mcur);
            end else begin
              chk($sformatf("beat d%0d c%0d #%0d", d, c, rp[mk]), mcur, sb[mk][rp[mk] % 512]);
              rp[mk]++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup_ar(input int d, input int c, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    araddr_d[d][c]  = a;
    arlen_d[d][c]   = len;
    arsize_d[d][c]  = sz;
    arburst_d[d][c] = bu;
  endtask

  // Raises arvalid on the masked channels; returns 1 ns after the acceptance edge.
  task automatic fire(input int d, input logic [NCH-1:0] mask);
    logic ok;
    ok = 1'b0;
    arvalid_d[d] = arvalid_d[d] | mask;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ((arready_m[d] & mask) == mask);
      tick();
    end
    arvalid_d[d] = arvalid_d[d] & ~mask;
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL ar_accept d%0d: got arready %0h expected %0h", d, arready_m[d], mask);
    end else begin
      for (int c = 0; c < NCH; c++)
        if (mask[c]) exp_cnt[d * NCH + c]++;
    end
  endtask

  task automatic wait_idle(input int d, input logic [NCH-1:0] mask);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (mask[c] && (busy_m[d][c] || rp[d * NCH + c] != wp[d * NCH + c])) done = 1'b0;
    end
    tick();
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        chk($sformatf("drained d%0d c%0d", d, c), (DW+3)'(wp[d * NCH + c] - rp[d * NCH + c]), '0);
        chk($sformatf("idle d%0d c%0d", d, c), (DW+3)'(busy_m[d][c]), '0);
        chk($sformatf("burst_cnt d%0d c%0d", d, c), (DW+3)'(cnt_m[d][c]), (DW+3)'(exp_cnt[d * NCH + c]));
      end
    end
  endtask

  // Counts negedges from the acceptance edge until rvalid is first seen.
  task automatic first_beat_latency(input int d, input int c, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) chk($sformatf("arready_drop d%0d c%0d", d, c), (DW+3)'(arready_m[d][c]), '0);
      if (rvalid_m[d][c]) break;
    end
    chk($sformatf("latency d%0d c%0d", d, c), (DW+3)'(n), (DW+3)'(exp_n));
    tick();
  endtask

  initial begin
    int unsigned hs0;
    logic [7:0]  pat;
    for (int k = 0; k < NQ; k++) held_v[k] = 1'b0;
    rst_d     = 2'b11;
    araddr_d  = '0;
    arlen_d   = '0;
    arsize_d  = '0;
    arburst_d = '0;
    arvalid_d = '0;
    rready_d  = '1;
    repeat (3) tick();
    rst_d = 2'b00;

    // Reset state of both instances
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rvalid d%0d", d), (DW+3)'(rvalid_m[d]), '0);
      chk($sformatf("rst_rlast d%0d", d), (DW+3)'(rlast_m[d]), '0);
      chk($sformatf("rst_arready d%0d", d), (DW+3)'(arready_m[d]), (DW+3)'(4'hF));
      chk($sformatf("rst_busy d%0d", d), (DW+3)'(busy_m[d]), '0);
      chk($sformatf("rst_cnt d%0d", d), (DW+3)'(cnt_m[d]), '0);
      chk($sformatf("rst_rresp d%0d", d), (DW+3)'(rresp_m[d]), '0);
      for (int c = 0; c < NCH; c++)
        chk($sformatf("rst_rdata d%0d c%0d", d, c), (DW+3)'(rdata_m[d][c]), '0);
    end
    tick();

    // Mode 0, latency 2: four beats 0..3, rlast on the fourth
    setup_ar(0, 0, 36'h100, 8'd3, 3'd4, 2'b01);
    push_idx(0, 3, 1'b0);
    fire(0, 4'b0001);
    first_beat_latency(0, 0, 3);
    wait_idle(0, 4'b0001);

    // Mode 1, INCR with arsize 7 (wider than the bus), then FIXED
    setup_ar(1, 2, 36'h1000, 8'd2, 3'd7, 2'b01);
    push(NCH + 2, DW'(36'h1000), 2'b00, 1'b0);
    push(NCH + 2, DW'(36'h1080), 2'b00, 1'b0);
    push(NCH + 2, DW'(36'h1100), 2'b00, 1'b1);
    fire(1, 4'b0100);
    first_beat_latency(1, 2, 1);
    wait_idle(1, 4'b0100);
    setup_ar(1, 2, 36'h1000, 8'd2, 3'd7, 2'b00);
    push(NCH + 2, DW'(36'h1000), 2'b00, 1'b0);
    push(NCH + 2, DW'(36'h1000), 2'b00, 1'b0);
    push(NCH + 2, DW'(36'h1000), 2'b00, 1'b1);
    fire(1, 4'b0100);
    wait_idle(1, 4'b0100);

    // Mode 1 address wrap at 2**36, then a WRAP burst answered with SLVERR
    setup_ar(1, 3, 36'hF_FFFF_FFC0, 8'd1, 3'd6, 2'b01);
    push(NCH + 3, DW'(36'hF_FFFF_FFC0), 2'b00, 1'b0);
    push(NCH + 3, DW'(0), 2'b00, 1'b1);
    fire(1, 4'b1000);
    wait_idle(1, 4'b1000);
    setup_ar(1, 3, 36'h20, 8'd0, 3'd3, 2'b10);
    push(NCH + 3, DW'(0), 2'b10, 1'b1);
    fire(1, 4'b1000);
    wait_idle(1, 4'b1000);

    // Backpressure: rready 1,0,0,1,1,0,1,1 repeating on a 5-beat burst
    pat = 8'b1101_1001;
    hs0 = hs[1];
    setup_ar(0, 1, 36'h40, 8'd4, 3'd4, 2'b01);
    push_idx(1, 4, 1'b0);
    fire(0, 4'b0010);
    for (int i = 0; i < 200; i++) begin
      rready_d[0][1] = pat[i % 8];
      tick();
      if (!busy_m[0][1] && rp[1] == wp[1]) break;
    end
    rready_d[0][1] = 1'b1;
    chk("stall_handshakes", (DW+3)'(hs[1] - hs0), (DW+3)'(5));
    wait_idle(0, 4'b0010);

    // Error injection: above MEM_LIMIT, exactly at MEM_LIMIT, a legal address, reserved burst
    setup_ar(0, 0, 36'h10000, 8'd1, 3'd4, 2'b01);
    push_idx(0, 1, 1'b1);
    fire(0, 4'b0001);
    wait_idle(0, 4'b0001);
    setup_ar(0, 0, 36'h20, 8'd0, 3'd4, 2'b01);
    push_idx(0, 0, 1'b0);
    fire(0, 4'b0001);
    wait_idle(0, 4'b0001);
    setup_ar(0, 0, 36'hFFFF, 8'd0, 3'd4, 2'b01);
    push_idx(0, 0, 1'b0);
    fire(0, 4'b0001);
    wait_idle(0, 4'b0001);
    setup_ar(0, 3, 36'h20, 8'd0, 3'd4, 2'b11);
    push_idx(3, 0, 1'b1);
    fire(0, 4'b1000);
    wait_idle(0, 4'b1000);

    // All four channels on the same edge with arlen 0, 1, 7, 255
    setup_ar(0, 0, 36'h0, 8'd0, 3'd4, 2'b01);
    setup_ar(0, 1, 36'h0, 8'd1, 3'd4, 2'b01);
    setup_ar(0, 2, 36'h0, 8'd7, 3'd4, 2'b01);
    setup_ar(0, 3, 36'h0, 8'd255, 3'd4, 2'b01);
    push_idx(0, 0, 1'b0);
    push_idx(1, 1, 1'b0);
    push_idx(2, 7, 1'b0);
    push_idx(3, 255, 1'b0);
    fire(0, 4'b1111);
    @(negedge clk);
    chk("multi_busy", (DW+3)'(busy_m[0]), (DW+3)'(4'hF));
    chk("multi_arready", (DW+3)'(arready_m[0]), '0);
    wait_idle(0, 4'b1111);

    // Reset while the third beat of an 8-beat burst is on the bus
    hs0 = hs[2];
    setup_ar(0, 2, 36'h80, 8'd7, 3'd4, 2'b01);
    push_idx(2, 7, 1'b0);
    fire(0, 4'b0100);
    repeat (4) tick();
    rst_d[0] = 1'b1;
    tick();
    rst_d[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", (DW+3)'(rvalid_m[0]), '0);
    chk("mid_rst_arready", (DW+3)'(arready_m[0]), (DW+3)'(4'hF));
    chk("mid_rst_cnt", (DW+3)'(cnt_m[0]), '0);
    chk("mid_rst_beats", (DW+3)'(hs[2] - hs0), (DW+3)'(2));
    tick();
    for (int c = 0; c < NCH; c++) begin
      rp[c] = wp[c];
      exp_cnt[c] = 0;
    end
    setup_ar(0, 2, 36'h80, 8'd1, 3'd4, 2'b01);
    push_idx(2, 1, 1'b0);
    fire(0, 4'b0100);
    wait_idle(0, 4'b0100);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
